// File: rtl/hazard_ctrl_multi.sv
// Pipeline hazard controller: load-use stalls with configurable latency,
// branch-in-ID dependency stalls, taken-branch IF/ID flush, post-reset
// warm-up window and a saturating stall-cycle counter.
module hazard_ctrl_multi #(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int WARMUP   = 4,
  parameter int PERF_W   = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [REG_W-1:0]  ID_Rs,
  input  logic [REG_W-1:0]  ID_Rt,
  input  logic              ID_UsesRt,
  input  logic              ID_Branch,
  input  logic              BranchTaken,
  input  logic              EX_MemRead,
  input  logic              EX_RegWrite,
  input  logic [REG_W-1:0]  EX_WriteReg,
  input  logic              MEM_MemRead,
  input  logic [REG_W-1:0]  MEM_WriteReg,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic              HazardControl,
  output logic              IFFlush,
  output logic [PERF_W-1:0] StallCount
);

  typedef enum logic [1:0] {
    WARM,
    RUN,
    LSTALL
  } state_t;

  localparam logic [3:0] LSTALL_INIT = 4'(LOAD_LAT - 1);
  localparam logic [4:0] WARM_END    = 5'(WARMUP);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [4:0] cnt_inc;

  logic ex_match, mem_match;
  logic load_use, branch_dep;
  logic pcw, ifidw, hc, flush;

  // Source-operand match against each producer; register 0 never matches.
  always_comb begin
    ex_match  = (EX_WriteReg != '0) &&
                ((EX_WriteReg == ID_Rs) || (ID_UsesRt && (EX_WriteReg == ID_Rt)));
    mem_match = (MEM_WriteReg != '0) &&
                ((MEM_WriteReg == ID_Rs) || (ID_UsesRt && (MEM_WriteReg == ID_Rt)));
    load_use   = EX_MemRead && ex_match;
    branch_dep = ID_Branch && ((EX_RegWrite && ex_match) || (MEM_MemRead && mem_match));
    cnt_inc    = {1'b0, cnt} + 5'd1;
  end

  // Next-state and control outputs; load-use > branch dependency > taken flush.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pcw     = 1'b1;
    ifidw   = 1'b1;
    hc      = 1'b0;
    flush   = 1'b0;
    unique case (state)
      WARM: begin
        cnt_n = cnt_inc[3:0];
        if ((WARMUP == 0) || (cnt_inc == WARM_END)) state_n = RUN;
      end
      RUN: begin
        if (load_use) begin
          pcw   = 1'b0;
          ifidw = 1'b0;
          hc    = 1'b1;
          if (LOAD_LAT > 1) begin
            state_n = LSTALL;
            cnt_n   = LSTALL_INIT;
          end
        end else if (branch_dep) begin
          pcw   = 1'b0;
          ifidw = 1'b0;
          hc    = 1'b1;
        end else if (ID_Branch && BranchTaken) begin
          flush = 1'b1;
        end
      end
      LSTALL: begin
        pcw   = 1'b0;
        ifidw = 1'b0;
        hc    = 1'b1;
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) state_n = RUN;
      end
      default: state_n = WARM;
    endcase
    // While reset is held the outputs already present the warm-up values,
    // so a stall in progress is not seen (or counted) during the reset cycle.
    if (Reset) begin
      pcw   = 1'b1;
      ifidw = 1'b1;
      hc    = 1'b0;
      flush = 1'b0;
    end
  end

  always_comb begin
    PCWrite       = pcw;
    IFIDWrite     = ifidw;
    HazardControl = hc;
    IFFlush       = flush;
  end

  // State, shared warm/stall counter and saturating stall-cycle counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= WARM;
      cnt        <= '0;
      StallCount <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (hc && (StallCount != '1)) StallCount <= StallCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_multi.sv
// Scoreboard bench for hazard_ctrl_multi: two instances (LOAD_LAT=3/PERF_W=16
// and LOAD_LAT=4/PERF_W=4) share the same stimulus; a cycle-level reference
// model pushes expected outputs, a negedge monitor pops and compares.
module tb_hazard_ctrl_multi;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [4:0] ID_Rs, ID_Rt, EX_WriteReg, MEM_WriteReg;
  logic       ID_UsesRt, ID_Branch, BranchTaken, EX_MemRead, EX_RegWrite, MEM_MemRead;

  logic        a_pcw, a_ifidw, a_hc, a_flush;
  logic [15:0] a_sc;
  logic        b_pcw, b_ifidw, b_hc, b_flush;
  logic [3:0]  b_sc;

  always #5 Clk = ~Clk;

  hazard_ctrl_multi #(.REG_W(5), .LOAD_LAT(3), .WARMUP(4), .PERF_W(16)) u_a (
    .Clk(Clk), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .ID_Branch(ID_Branch), .BranchTaken(BranchTaken), .EX_MemRead(EX_MemRead),
    .EX_RegWrite(EX_RegWrite), .EX_WriteReg(EX_WriteReg), .MEM_MemRead(MEM_MemRead),
    .MEM_WriteReg(MEM_WriteReg), .PCWrite(a_pcw), .IFIDWrite(a_ifidw),
    .HazardControl(a_hc), .IFFlush(a_flush), .StallCount(a_sc));

  hazard_ctrl_multi #(.REG_W(5), .LOAD_LAT(4), .WARMUP(4), .PERF_W(4)) u_b (
    .Clk(Clk), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .ID_Branch(ID_Branch), .BranchTaken(BranchTaken), .EX_MemRead(EX_MemRead),
    .EX_RegWrite(EX_RegWrite), .EX_WriteReg(EX_WriteReg), .MEM_MemRead(MEM_MemRead),
    .MEM_WriteReg(MEM_WriteReg), .PCWrite(b_pcw), .IFIDWrite(b_ifidw),
    .HazardControl(b_hc), .IFFlush(b_flush), .StallCount(b_sc));

  // Expected control vectors are {PCWrite, IFIDWrite, HazardControl, IFFlush}.
  typedef struct {
    logic [3:0]  ctrl_a;
    logic [15:0] sc_a;
    logic [3:0]  ctrl_b;
    logic [3:0]  sc_b;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state per instance: warm cycles still to go, extra stall
  // cycles still owed after a load-use, and the stall tally.
  int warm_left[2];
  int stall_left[2];
  int tally[2];
  int lat[2]  = '{3, 4};
  int maxc[2] = '{65535, 15};

  function automatic logic src_match(input logic [4:0] d);
    return (d != 5'd0) && ((d == ID_Rs) || (ID_UsesRt && (d == ID_Rt)));
  endfunction

  task automatic idle();
    Reset = 1'b0; ID_Rs = '0; ID_Rt = '0; ID_UsesRt = 1'b0; ID_Branch = 1'b0;
    BranchTaken = 1'b0; EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_WriteReg = '0;
    MEM_MemRead = 1'b0; MEM_WriteReg = '0;
  endtask

  // Predict this cycle's outputs from the current inputs, queue them, advance.
  task automatic step();
    exp_t       e;
    logic [3:0] o [2];
    for (int unsigned i = 0; i < 2; i++) begin
      if (Reset) begin
        o[i] = 4'b1100;
      end else if (warm_left[i] > 0) begin
        o[i] = 4'b1100;
        warm_left[i]--;
      end else if (stall_left[i] > 0) begin
        o[i] = 4'b0010;
        stall_left[i]--;
      end else if (EX_MemRead && src_match(EX_WriteReg)) begin
        o[i] = 4'b0010;
        stall_left[i] = lat[i] - 1;
      end else if (ID_Branch && ((EX_RegWrite && src_match(EX_WriteReg)) ||
                                 (MEM_MemRead && src_match(MEM_WriteReg)))) begin
        o[i] = 4'b0010;
      end else if (ID_Branch && BranchTaken) begin
        o[i] = 4'b1101;
      end else begin
        o[i] = 4'b1100;
      end
    end
    e.ctrl_a = o[0];
    e.sc_a   = 16'(tally[0]);
    e.ctrl_b = o[1];
    e.sc_b   = 4'(tally[1]);
    q.push_back(e);
    for (int unsigned i = 0; i < 2; i++) begin
      if (Reset) begin
        warm_left[i]  = 4;
        stall_left[i] = 0;
        tally[i]      = 0;
      end else if (o[i][1] && tally[i] < maxc[i]) begin
        tally[i]++;
      end
    end
    @(posedge Clk);
    #1;
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
  always @(negedge Clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({a_pcw, a_ifidw, a_hc, a_flush} !== e.ctrl_a) begin
        errors++;
        $display("FAIL ctrl_a t=%0t got %b want %b", $time, {a_pcw, a_ifidw, a_hc, a_flush}, e.ctrl_a);
      end
      checks++;
      if (a_sc !== e.sc_a) begin
        errors++;
        $display("FAIL stallcount_a t=%0t got %0d want %0d", $time, a_sc, e.sc_a);
      end
      checks++;
      if ({b_pcw, b_ifidw, b_hc, b_flush} !== e.ctrl_b) begin
        errors++;
        $display("FAIL ctrl_b t=%0t got %b want %b", $time, {b_pcw, b_ifidw, b_hc, b_flush}, e.ctrl_b);
      end
      checks++;
      if (b_sc !== e.sc_b) begin
        errors++;
        $display("FAIL stallcount_b t=%0t got %0d want %0d", $time, b_sc, e.sc_b);
      end
    end
  end

  initial begin
    idle();
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    // Reset cycle, then warm-up with a load-use pattern in warm cycle 3.
    Reset = 1'b1; step();
    idle(); step();
    step();
    EX_MemRead = 1'b1; EX_WriteReg = 5'd8; ID_Rs = 5'd8; step();
    idle(); step();
    step();  // first RUN cycle
    // Load-use through Rt.
    EX_MemRead = 1'b1; EX_WriteReg = 5'd9; ID_Rt = 5'd9; ID_UsesRt = 1'b1; step();
    idle(); repeat (5) step();
    // Register 0 and unused Rt never match.
    EX_MemRead = 1'b1; EX_WriteReg = 5'd0; ID_Rs = 5'd0; step();
    EX_WriteReg = 5'd9; ID_Rt = 5'd9; ID_UsesRt = 1'b0; ID_Rs = 5'd3; step();
    // Branch dependency on EX, then taken flush once cleared.
    idle(); ID_Branch = 1'b1; BranchTaken = 1'b1; EX_RegWrite = 1'b1;
    EX_WriteReg = 5'd4; ID_Rs = 5'd4; step();
    EX_WriteReg = 5'd5; step();
    // Branch dependency on a MEM-stage load through Rt.
    idle(); ID_Branch = 1'b1; MEM_MemRead = 1'b1; MEM_WriteReg = 5'd7;
    ID_Rt = 5'd7; ID_UsesRt = 1'b1; step();
    // Load-use beats branch; reset lands on the 2nd stall cycle.
    idle(); ID_Branch = 1'b1; BranchTaken = 1'b1; EX_MemRead = 1'b1;
    EX_WriteReg = 5'd2; ID_Rs = 5'd2; step();
    idle(); Reset = 1'b1; step();
    idle(); repeat (6) step();
    // Continuous load-use long enough to saturate the 4-bit counter.
    EX_MemRead = 1'b1; EX_WriteReg = 5'd1; ID_Rs = 5'd1; repeat (24) step();
    idle(); step();
    // Randomised traffic over a small register range to force frequent matches.
    for (int n = 0; n < 500; n++) begin
      Reset        = ($urandom_range(0, 59) == 0);
      ID_Rs        = 5'($urandom_range(0, 3));
      ID_Rt        = 5'($urandom_range(0, 3));
      ID_UsesRt    = 1'($urandom);
      ID_Branch    = 1'($urandom);
      BranchTaken  = 1'($urandom);
      EX_MemRead   = ($urandom_range(0, 3) == 0);
      EX_RegWrite  = 1'($urandom);
      EX_WriteReg  = 5'($urandom_range(0, 3));
      MEM_MemRead  = 1'($urandom);
      MEM_WriteReg = 5'($urandom_range(0, 3));
      step();
    end
    idle();
    for (int w = 0; w < 5 && q.size() > 0; w++) @(posedge Clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
